// File: rtl/dds_if.sv
// DAC-side output bundle of the DDS function generator: sample clock, sample bus and sync square.
// The master drives all three signals; a DAC model or board wrapper takes the slave view.
interface dds_if;
    logic       Fg_CLK;
    logic       Dac_CLK;
    logic [7:0] oDacData;

    modport master (output Fg_CLK, output Dac_CLK, output oDacData);
    modport slave  (input  Fg_CLK, input  Dac_CLK, input  oDacData);
endinterface

// File: rtl/dds_top.sv
// DDS function generator: 32-bit phase accumulator at Ext_CLK/2, four waveforms, debounced mode button.
// Optional macro DDS_MODE_OUT_EN exposes the current waveform mode on oMode.
module dds_top #(
    parameter logic [31:0] TUNING_WORD     = 32'h0147AE14,
    parameter int          DEBOUNCE_CYCLES = 32
) (
    input  logic       Ext_CLK,
    input  logic       Ext_RESET,
    input  logic       iExtBtn,
`ifdef DDS_MODE_OUT_EN
    output logic [1:0] oMode,
`endif
    dds_if.master      dac
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             dac_clk;
    logic             fg_clk;
    logic [7:0]       dac_data;
    logic [31:0]      acc;
    logic [31:0]      acc_next;
    logic             sample_en;
    logic [1:0]       mode;
    logic             btn_meta;
    logic             btn_sync;
    logic             btn_deb;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_flip;
    logic             press;

    // Quarter-wave table: round(127*sin(2*pi*(k+0.5)/256)), k = 0..63.
    function automatic logic [6:0] sine_lut(input logic [5:0] q);
        sine_lut = 7'd0;
        case (q)
            6'd0:  sine_lut = 7'd2;
            6'd1:  sine_lut = 7'd5;
            6'd2:  sine_lut = 7'd8;
            6'd3:  sine_lut = 7'd11;
            6'd4:  sine_lut = 7'd14;
            6'd5:  sine_lut = 7'd17;
            6'd6:  sine_lut = 7'd20;
            6'd7:  sine_lut = 7'd23;
            6'd8:  sine_lut = 7'd26;
            6'd9:  sine_lut = 7'd29;
            6'd10: sine_lut = 7'd32;
            6'd11: sine_lut = 7'd35;
            6'd12: sine_lut = 7'd38;
            6'd13: sine_lut = 7'd41;
            6'd14: sine_lut = 7'd44;
            6'd15: sine_lut = 7'd47;
            6'd16: sine_lut = 7'd50;
            6'd17: sine_lut = 7'd53;
            6'd18: sine_lut = 7'd56;
            6'd19: sine_lut = 7'd58;
            6'd20: sine_lut = 7'd61;
            6'd21: sine_lut = 7'd64;
            6'd22: sine_lut = 7'd67;
            6'd23: sine_lut = 7'd69;
            6'd24: sine_lut = 7'd72;
            6'd25: sine_lut = 7'd74;
            6'd26: sine_lut = 7'd77;
            6'd27: sine_lut = 7'd79;
            6'd28: sine_lut = 7'd82;
            6'd29: sine_lut = 7'd84;
            6'd30: sine_lut = 7'd86;
            6'd31: sine_lut = 7'd89;
            6'd32: sine_lut = 7'd91;
            6'd33: sine_lut = 7'd93;
            6'd34: sine_lut = 7'd95;
            6'd35: sine_lut = 7'd97;
            6'd36: sine_lut = 7'd99;
            6'd37: sine_lut = 7'd101;
            6'd38: sine_lut = 7'd103;
            6'd39: sine_lut = 7'd105;
            6'd40: sine_lut = 7'd106;
            6'd41: sine_lut = 7'd108;
            6'd42: sine_lut = 7'd110;
            6'd43: sine_lut = 7'd111;
            6'd44: sine_lut = 7'd113;
            6'd45: sine_lut = 7'd114;
            6'd46: sine_lut = 7'd115;
            6'd47: sine_lut = 7'd117;
            6'd48: sine_lut = 7'd118;
            6'd49: sine_lut = 7'd119;
            6'd50: sine_lut = 7'd120;
            6'd51: sine_lut = 7'd121;
            6'd52: sine_lut = 7'd122;
            6'd53: sine_lut = 7'd123;
            6'd54: sine_lut = 7'd124;
            6'd55: sine_lut = 7'd124;
            6'd56: sine_lut = 7'd125;
            6'd57: sine_lut = 7'd125;
            6'd58: sine_lut = 7'd126;
            6'd59: sine_lut = 7'd126;
            6'd60: sine_lut = 7'd127;
            6'd61: sine_lut = 7'd127;
            6'd62: sine_lut = 7'd127;
            6'd63: sine_lut = 7'd127;
        endcase
    endfunction

    function automatic logic [7:0] wave(input logic [7:0] p, input logic [1:0] m);
        logic [5:0] q;
        logic [7:0] mag;
        q    = p[6] ? ~p[5:0] : p[5:0];
        mag  = {1'b0, sine_lut(q)};
        wave = 8'h80;
        case (m)
            2'd0: wave = p[7] ? (8'd128 - mag) : (8'd128 + mag);
            2'd1: wave = p[7] ? 8'h00 : 8'hFF;
            2'd2: wave = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            2'd3: wave = p;
        endcase
    endfunction

    // Samples update in the Dac_CLK-high cycle so new data lands on its falling edge.
    assign sample_en = dac_clk;
    assign acc_next  = acc + TUNING_WORD;

    always_ff @(posedge Ext_CLK or posedge Ext_RESET) begin
        if (Ext_RESET) dac_clk <= 1'b0;
        else           dac_clk <= ~dac_clk;
    end

    always_ff @(posedge Ext_CLK or posedge Ext_RESET) begin
        if (Ext_RESET) begin
            acc      <= 32'd0;
            fg_clk   <= 1'b0;
            dac_data <= 8'h80;
        end else if (sample_en) begin
            acc      <= acc_next;
            fg_clk   <= acc_next[31];
            dac_data <= wave(acc_next[31:24], mode);
        end
    end

    always_ff @(posedge Ext_CLK or posedge Ext_RESET) begin
        if (Ext_RESET) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= iExtBtn;
            btn_sync <= btn_meta;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted one.
    assign deb_flip = (btn_sync != btn_deb) && (deb_cnt == CNT_MAX);
    assign press    = deb_flip && !btn_sync;

    always_ff @(posedge Ext_CLK or posedge Ext_RESET) begin
        if (Ext_RESET) begin
            btn_deb <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_sync == btn_deb) begin
            deb_cnt <= '0;
        end else if (deb_flip) begin
            btn_deb <= btn_sync;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Accumulator is left untouched on a mode change, so the switch is phase-continuous.
    always_ff @(posedge Ext_CLK or posedge Ext_RESET) begin
        if (Ext_RESET)  mode <= 2'd0;
        else if (press) mode <= mode + 2'd1;
    end

    assign dac.Dac_CLK  = dac_clk;
    assign dac.Fg_CLK   = fg_clk;
    assign dac.oDacData = dac_data;

`ifdef DDS_MODE_OUT_EN
    assign oMode = mode;
`endif

endmodule

// File: tb/tb_dds_top.sv
// Bench for dds_top: cycle-by-cycle comparison against a phase/time model built from sin() and sample counts.
module tb_dds_top;

    localparam logic [31:0] TW = 32'h0147AE14;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    dds_if dac();
`ifdef DDS_MODE_OUT_EN
    logic [1:0] mode_o;
`endif

    dds_top dut (
        .Ext_CLK   (clk),
        .Ext_RESET (rst),
        .iExtBtn   (btn),
`ifdef DDS_MODE_OUT_EN
        .oMode     (mode_o),
`endif
        .dac       (dac)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int k;          // posedges since reset release
    int exp_mode;   // settled mode
    int pend_mode;  // mode after the press in flight
    int pend_k;     // posedge index where the press reached the synchronizer, -1 if none

    function automatic logic [7:0] ref_wave(input logic [7:0] p, input int m);
        real s;
        int  mag;
        int  r;
        s   = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 256.0);
        mag = $rtoi(((s < 0.0) ? -s : s) + 0.5);
        case (m)
            0:       r = (s >= 0.0) ? 128 + mag : 128 - mag;
            1:       r = (p < 128) ? 255 : 0;
            2:       r = (p < 128) ? 2 * int'(p) : 255 - 2 * (int'(p) - 128);
            default: r = int'(p);
        endcase
        return 8'(r);
    endfunction

    task automatic check_outputs();
        logic [31:0] acc;
        logic [7:0]  exp_data;
        logic        exp_dclk;
        int          n;
        bit          skip;
        n    = k / 2;
        acc  = TW * 32'(n);
        skip = 1'b0;
        if (pend_k >= 0) begin
            if (k > pend_k + 40) begin
                exp_mode = pend_mode;
                pend_k   = -1;
            end else if (k >= pend_k + 28) begin
                skip = 1'b1;
            end
        end
        exp_dclk = 1'(k & 1);
        exp_data = (n == 0) ? 8'h80 : ref_wave(acc[31:24], exp_mode);
        tests++;
        assert (dac.Dac_CLK === exp_dclk) else begin
            fails++;
            $error("FAIL dac_clk k=%0d observed=%0b expected=%0b", k, dac.Dac_CLK, exp_dclk);
        end
        tests++;
        assert (dac.Fg_CLK === acc[31]) else begin
            fails++;
            $error("FAIL fg_clk k=%0d observed=%0b expected=%0b", k, dac.Fg_CLK, acc[31]);
        end
        if (!skip) begin
            tests++;
            assert (dac.oDacData === exp_data) else begin
                fails++;
                $error("FAIL dac_data k=%0d mode=%0d observed=%0h expected=%0h",
                       k, exp_mode, dac.oDacData, exp_data);
            end
`ifdef DDS_MODE_OUT_EN
            tests++;
            assert (mode_o === 2'(exp_mode)) else begin
                fails++;
                $error("FAIL mode_out k=%0d observed=%0d expected=%0d", k, mode_o, exp_mode);
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        #1;
        check_outputs();
    endtask

    task automatic run(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic press_valid(input int low_cycles);
        btn       = 1'b0;
        pend_k    = k + 1;
        pend_mode = (exp_mode + 1) % 4;
        run(low_cycles);
        btn = 1'b1;
    endtask

    task automatic glitch(input int low_cycles);
        btn = 1'b0;
        run(low_cycles);
        btn = 1'b1;
    endtask

    // Called #1 after a posedge: a 5 ns pulse that never spans a rising edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        tests++;
        assert (dac.Dac_CLK === 1'b0) else begin
            fails++;
            $error("FAIL rst_dac_clk observed=%0b expected=0", dac.Dac_CLK);
        end
        tests++;
        assert (dac.Fg_CLK === 1'b0) else begin
            fails++;
            $error("FAIL rst_fg_clk observed=%0b expected=0", dac.Fg_CLK);
        end
        tests++;
        assert (dac.oDacData === 8'h80) else begin
            fails++;
            $error("FAIL rst_dac_data observed=%0h expected=80", dac.oDacData);
        end
        #2;
        rst      = 1'b0;
        k        = 0;
        exp_mode = 0;
        pend_k   = -1;
    endtask

    initial begin
        rst      = 1'b1;
        btn      = 1'b1;
        k        = 0;
        exp_mode = 0;
        pend_k   = -1;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();

        // Sine from reset, past the first accumulator MSB rise and wrap.
        run(450);

        // One press -> square.
        press_valid($urandom_range(45, 60));
        run(240);

        // Short glitches are rejected.
        for (int i = 0; i < 3; i++) begin
            glitch($urandom_range(2, 20));
            run($urandom_range(60, 120));
        end

        // Two more presses -> sawtooth.
        press_valid(50);
        run($urandom_range(200, 260));
        press_valid(50);
        run(240);

        // 3 wraps to 0, then on to 1 and 2.
        for (int i = 0; i < 3; i++) begin
            press_valid($urandom_range(40, 70));
            run($urandom_range(200, 260));
        end

        // Reset in mode 2: back to sine immediately.
        pulse_reset();
        run(300);

        // Button held low through reset release counts as one press.
        btn = 1'b0;
        pulse_reset();
        pend_k    = 1;
        pend_mode = 1;
        run(60);
        btn = 1'b1;
        run(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
